playback_streamer: RTL and testbench

Sample-fetch and pacing stage that sits directly upstream of the Audio_Controller on the DAC path. It walks the sample ROM address space, absorbs the ROM read latency, applies a power-of-two volume attenuation, and pushes each sample into the codec output FIFO a fixed number of times, writing only while the controller reports space. Transport control is start/stop/pause, with optional looping. It replaces free-running frame-counter pacing, so the codec FIFO's backpressure sets the playback rate.

---
 rtl/playback_streamer.sv | 120 ++++++++++++
 tb/tb_playback_streamer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/playback_streamer.sv
// Sample fetch/pacing stage ahead of the codec FIFO: walks the ROM, waits out its
// read latency, attenuates, and emits each sample REPEAT times under FIFO backpressure.
module playback_streamer #(
  parameter int ROM_SIZE     = 156151,
  parameter int ADDR_WIDTH   = 18,
  parameter int SAMPLE_WIDTH = 32,
  parameter int ROM_LATENCY  = 2,
  parameter int REPEAT       = 10
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    pause,
  input  logic                    loop_enable,
  input  logic [1:0]              volume_shift,
  output logic [ADDR_WIDTH-1:0]   rom_address,
  input  logic [SAMPLE_WIDTH-1:0] rom_data,
  input  logic                    audio_out_allowed,
  output logic [SAMPLE_WIDTH-1:0] left_channel_audio_out,
  output logic [SAMPLE_WIDTH-1:0] right_channel_audio_out,
  output logic                    write_audio_out,
  output logic                    playing,
  output logic                    done
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_EMIT  = 2'd3;
  localparam int LW = $clog2(ROM_LATENCY + 1);
  localparam int RW = $clog2(REPEAT + 1);

  logic [1:0]              state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LW-1:0]           lat_q, lat_d;
  logic [RW-1:0]           rep_q, rep_d;
  logic [SAMPLE_WIDTH-1:0] smp_q, smp_d;
  logic                    done_q, done_d;
  logic                    wr, last_write, last_addr;
  logic signed [SAMPLE_WIDTH-1:0] shifted;

  // Reset is folded in so no strobe reaches the codec on the reset edge.
  assign wr         = (state_q == S_EMIT) & audio_out_allowed & ~pause & ~stop & ~reset;
  assign last_write = wr & (rep_q == RW'(1));
  assign last_addr  = (addr_q == ADDR_WIDTH'(ROM_SIZE - 1));
  assign shifted    = $signed(rom_data) >>> volume_shift;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lat_d   = lat_q;
    rep_d   = rep_q;
    smp_d   = smp_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        state_d = S_WAIT;
        lat_d   = LW'(ROM_LATENCY);
      end
      S_WAIT: begin
        lat_d = lat_q - LW'(1);
        if (lat_q == LW'(1)) begin
          smp_d   = shifted;
          rep_d   = RW'(REPEAT);
          state_d = S_EMIT;
        end
      end
      default: begin
        if (wr) rep_d = rep_q - RW'(1);
        if (last_write) begin
          if (!last_addr) begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = S_FETCH;
          end else begin
            addr_d = '0;
            if (loop_enable) state_d = S_FETCH;
            else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
    endcase
    // Stop overrides everything, including a same-cycle start.
    if (stop) begin
      state_d = S_IDLE;
      addr_d  = '0;
      lat_d   = '0;
      rep_d   = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      lat_q   <= '0;
      rep_q   <= '0;
      smp_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lat_q   <= lat_d;
      rep_q   <= rep_d;
      smp_q   <= smp_d;
      done_q  <= done_d;
    end
  end

  assign rom_address             = addr_q;
  assign left_channel_audio_out  = smp_q;
  assign right_channel_audio_out = smp_q;
  assign write_audio_out         = wr;
  assign playing                 = (state_q != S_IDLE);
  assign done                    = done_q;
endmodule

// File: tb/tb_playback_streamer.sv
// Scoreboard bench for playback_streamer: 4-sample ROM, REPEAT=2, 2-cycle ROM latency.
module tb_playback_streamer;
  localparam int RS = 4, AW = 18, SW = 32, LAT = 2, REP = 2;

  logic          clk = 1'b0;
  logic          reset, start, stop, pause, loop_enable, audio_out_allowed;
  logic [1:0]    volume_shift;
  logic [AW-1:0] rom_address;
  logic [SW-1:0] rom_data, left, right;
  logic          write_audio_out, playing, done;

  logic [SW-1:0] rom_mem [RS];
  logic [SW-1:0] rom_p0, rom_p1;
  logic [SW-1:0] sb [$];
  int checks = 0, failures = 0;

  playback_streamer #(.ROM_SIZE(RS), .ADDR_WIDTH(AW), .SAMPLE_WIDTH(SW),
                      .ROM_LATENCY(LAT), .REPEAT(REP)) dut (
    .CLOCK_50(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .loop_enable(loop_enable), .volume_shift(volume_shift), .rom_address(rom_address),
    .rom_data(rom_data), .audio_out_allowed(audio_out_allowed),
    .left_channel_audio_out(left), .right_channel_audio_out(right),
    .write_audio_out(write_audio_out), .playing(playing), .done(done));

  always #5 clk = ~clk;

  // Two-stage synchronous ROM model
  always @(posedge clk) begin
    rom_p0 <= rom_mem[rom_address[1:0]];
    rom_p1 <= rom_p0;
  end
  assign rom_data = rom_p1;

  // Scoreboard: every codec write must match the next queued sample on both channels
  always @(negedge clk) begin
    if (write_audio_out === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write got=%h expected no write", left);
      end else begin
        logic [SW-1:0] e;
        e = sb.pop_front();
        if (left !== e || right !== e) begin
          failures++;
          $display("FAIL write_value left=%h right=%h expected=%h", left, right, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_pass(input logic [1:0] sh);
    for (int i = 0; i < RS; i++)
      for (int r = 0; r < REP; r++) sb.push_back(SW'($signed(rom_mem[i]) >>> sh));
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_drain pending=%0d expected=0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick(); #1;
    checks++;
    if (rom_address !== '0 || left !== '0 || right !== '0 || write_audio_out !== 1'b0 ||
        playing !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state addr=%0d l=%h r=%h wr=%b play=%b done=%b expected all 0",
               rom_address, left, right, write_audio_out, playing, done);
    end
    reset = 1'b0; tick();
  endtask

  task automatic test_basic();
    push_pass(2'd0);
    pulse_start();
    for (int k = 0; k <= 21; k++) begin
      logic ew;
      ew = (k < 20) && (k % 5 == 3 || k % 5 == 4);
      #1;
      checks++;
      if (write_audio_out !== ew || done !== (k == 20)) begin
        failures++;
        $display("FAIL basic_timing k=%0d wr=%b done=%b expected wr=%b done=%b",
                 k, write_audio_out, done, ew, k == 20);
      end
      if (k == 21) begin
        checks++;
        if (playing !== 1'b0 || rom_address !== '0) begin
          failures++;
          $display("FAIL basic_end play=%b addr=%0d expected 0 0", playing, rom_address);
        end
      end
      tick();
    end
    check_drained("basic");
  endtask

  task automatic test_loop();
    int n;
    loop_enable = 1'b1;
    push_pass(2'd0);
    for (int r = 0; r < REP; r++) sb.push_back(rom_mem[0]);
    for (int r = 0; r < REP; r++) sb.push_back(rom_mem[1]);
    pulse_start();
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      checks++;
      if (done !== 1'b0) begin
        failures++;
        $display("FAIL loop_done got=%b expected=0", done);
      end
      tick(); n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL loop_timeout pending=%0d expected=0", sb.size());
      sb.delete();
    end
    stop = 1'b1; tick(); stop = 1'b0;
    for (int k = 0; k < 12; k++) begin
      #1;
      checks++;
      if (write_audio_out !== 1'b0 || done !== 1'b0 || playing !== 1'b0 || rom_address !== '0) begin
        failures++;
        $display("FAIL loop_stop wr=%b done=%b play=%b addr=%0d expected 0 0 0 0",
                 write_audio_out, done, playing, rom_address);
      end
      tick();
    end
    loop_enable = 1'b0;
  endtask

  task automatic test_backpressure();
    int nw, k;
    logic [SW-1:0] held;
    logic seen_done;
    push_pass(2'd0);
    pulse_start();
    nw = 0; seen_done = 1'b0; held = '0;
    for (k = 0; k < 200 && !seen_done; k++) begin
      audio_out_allowed = k[0];
      pause = (k >= 4 && k < 9);
      #1;
      if (write_audio_out === 1'b1) nw++;
      checks++;
      if (write_audio_out === 1'b1 && (!audio_out_allowed || pause)) begin
        failures++;
        $display("FAIL bp_gating k=%0d wr=1 allowed=%b pause=%b expected wr=0",
                 k, audio_out_allowed, pause);
      end
      if (k == 4) held = left;
      if (k > 4 && k < 9) begin
        checks++;
        if (left !== held) begin
          failures++;
          $display("FAIL bp_hold k=%0d got=%h expected=%h", k, left, held);
        end
      end
      seen_done = (done === 1'b1);
      tick();
    end
    audio_out_allowed = 1'b1; pause = 1'b0;
    checks++;
    if (!seen_done || nw != RS * REP) begin
      failures++;
      $display("FAIL bp_count writes=%0d done=%b expected writes=%0d done=1", nw, seen_done, RS * REP);
    end
    check_drained("bp");
  endtask

  task automatic test_volume();
    logic [SW-1:0] vals [2];
    logic [1:0] shs [2];
    logic [SW-1:0] exps [2];
    vals[0] = 32'h8000_0000; shs[0] = 2'd2; exps[0] = 32'hE000_0000;
    vals[1] = 32'h0000_0100; shs[1] = 2'd3; exps[1] = 32'h0000_0020;
    for (int t = 0; t < 2; t++) begin
      int n;
      rom_mem[0] = vals[t]; volume_shift = shs[t];
      for (int r = 0; r < REP; r++) sb.push_back(exps[t]);
      tick(); tick(); tick();
      pulse_start();
      n = 0;
      while (sb.size() != 0 && n < 30) begin tick(); n++; end
      check_drained("volume");
      stop = 1'b1; tick(); stop = 1'b0;
    end
    rom_mem[0] = 32'd1; volume_shift = 2'd0;
    tick(); tick(); tick();
  endtask

  task automatic test_races();
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (playing !== 1'b0 || write_audio_out !== 1'b0) begin
        failures++;
        $display("FAIL race_startstop play=%b wr=%b expected 0 0", playing, write_audio_out);
      end
      tick();
    end
    pulse_start();
    tick();
    stop = 1'b1; tick(); stop = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if (playing !== 1'b0 || write_audio_out !== 1'b0 || rom_address !== '0) begin
        failures++;
        $display("FAIL race_stop_wait play=%b wr=%b addr=%0d expected 0 0 0",
                 playing, write_audio_out, rom_address);
      end
      tick();
    end
  endtask

  task automatic test_start_while_playing();
    push_pass(2'd0);
    pulse_start();
    for (int k = 0; k <= 21; k++) begin
      logic ew;
      start = (k == 6 || k == 13);
      ew = (k < 20) && (k % 5 == 3 || k % 5 == 4);
      #1;
      checks++;
      if (write_audio_out !== ew || done !== (k == 20)) begin
        failures++;
        $display("FAIL restart_timing k=%0d wr=%b done=%b expected wr=%b done=%b",
                 k, write_audio_out, done, ew, k == 20);
      end
      tick();
    end
    start = 1'b0;
    check_drained("restart");
  endtask

  task automatic test_reset_mid_emit();
    int n;
    logic seen_done;
    sb.push_back(rom_mem[0]);
    pulse_start();
    for (int k = 0; k < 4; k++) tick();
    reset = 1'b1;
    #1;
    checks++;
    if (write_audio_out !== 1'b0) begin
      failures++;
      $display("FAIL rst_cycle_write got=%b expected=0", write_audio_out);
    end
    tick(); reset = 1'b0; #1;
    checks++;
    if (rom_address !== '0 || left !== '0 || right !== '0 || write_audio_out !== 1'b0 ||
        playing !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_state addr=%0d l=%h r=%h wr=%b play=%b done=%b expected all 0",
               rom_address, left, right, write_audio_out, playing, done);
    end
    check_drained("rst_mid");
    tick(); tick();
    push_pass(2'd0);
    pulse_start();
    n = 0; seen_done = 1'b0;
    while (!seen_done && n < 60) begin
      #1; seen_done = (done === 1'b1);
      tick(); n++;
    end
    checks++;
    if (!seen_done) begin
      failures++;
      $display("FAIL rst_replay_done got=0 expected=1");
    end
    check_drained("rst_replay");
  endtask

  initial begin
    for (int i = 0; i < RS; i++) rom_mem[i] = SW'(i + 1);
    reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_enable = 1'b0;
    audio_out_allowed = 1'b1; volume_shift = 2'd0;
    test_reset();
    test_basic();
    test_loop();
    test_backpressure();
    test_volume();
    test_races();
    test_start_while_playing();
    test_reset_mid_emit();
    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
